// File: rtl/dac_stream_driver.sv
// dac_stream_driver
//   DAC output stage. Selects a source word (FSM stream, static word,
//   triggered calibration pulse or ramp pattern), delays it by a programmable
//   number of whole cycles plus a sub-cycle sample shift and drives the DAC.
//   All control registers are written over the shared 32-bit GPIO bus.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   gpio_in         config bus: [15:0] addr, [23:16] data, [24] write strobe
//   fsm_val_in      FSM sample word, sample 0 (LSBs) earliest in time
//   fsm_in_valid    fsm_val_in qualifier
//   del_trig        calibration trigger level, rising edge acts
//   dac_out         DAC sample word
//   dac_out_valid   dac_out qualifier
//   cal_busy        calibration pulse in progress
module dac_stream_driver #(
   parameter int SAMPLE_W      = 16,
   parameter int NUM_SAMPLES   = 16,
   parameter int MAX_CYC_DELAY = 16,
   parameter int BASE_ADDR     = 0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [31:0]                     gpio_in,
   input  logic [SAMPLE_W*NUM_SAMPLES-1:0] fsm_val_in,
   input  logic                            fsm_in_valid,
   input  logic                            del_trig,
   output logic [SAMPLE_W*NUM_SAMPLES-1:0] dac_out,
   output logic                            dac_out_valid,
   output logic                            cal_busy
);

   localparam int W  = SAMPLE_W * NUM_SAMPLES;
   localparam int NB = W / 8;
   localparam int DW = (MAX_CYC_DELAY > 1) ? $clog2(MAX_CYC_DELAY) : 1;
   localparam logic [7:0] SHIFT_MAX = 8'(NUM_SAMPLES - 1);
   localparam logic [7:0] CYC_MAX   = 8'(MAX_CYC_DELAY - 1);

   // configuration registers
   logic [24:0]   gpio_q;
   logic          wclk_prev_q;
   logic [1:0]    mode_q;
   logic [7:0]    shift_q;
   logic [7:0]    cyc_q;
   logic [7:0]    cal_len_q;
   logic [W-1:0]  static_q;

   logic          wr_fire_s;
   logic [15:0]   wr_addr_s;
   logic [15:0]   wr_off_s;
   logic [7:0]    wr_data_s;
   logic          unused_gpio_s;

   // effective (clamped) settings
   logic [7:0]    shift_eff_s;
   logic [DW-1:0] cyc_eff_s;
   logic [7:0]    cal_len_eff_s;

   // stage 1
   logic          trig_q;
   logic          rise_s;
   logic [7:0]    cal_cnt_q, cal_cnt_d;
   logic          cal_busy_q;
   logic [SAMPLE_W-1:0] ramp_c_q, ramp_c_d;
   logic [SAMPLE_W-1:0] ramp_base_s;
   logic [W-1:0]  ramp_word_s;
   logic [W-1:0]  s1_data_q, s1_data_d;
   logic          s1_valid_q, s1_valid_d;

   // stage 2
   logic [W-1:0]  dl_mem_q [MAX_CYC_DELAY];
   logic [MAX_CYC_DELAY-1:0] dl_vld_q;
   logic [DW-1:0] wr_ptr_q;
   logic [DW-1:0] rd_idx_s;
   logic [W-1:0]  s2_data_q, s2_prev_q;
   logic          s2_valid_q, s2_prev_valid_q;

   // stage 3
   logic [2*W-1:0] cat_s;
   logic [15:0]   shamt_s;
   logic [W-1:0]  out_q;
   logic          out_valid_q;

   assign unused_gpio_s = ^gpio_in[31:25];

   // The strobe fires on the rising edge of the registered w_clk bit; addr
   // and data come from the same registered copy so they are stable.
   assign wr_fire_s = gpio_q[24] & ~wclk_prev_q;
   assign wr_addr_s = gpio_q[15:0];
   assign wr_data_s = gpio_q[23:16];
   assign wr_off_s  = wr_addr_s - 16'(BASE_ADDR);

   assign shift_eff_s   = (shift_q > SHIFT_MAX) ? SHIFT_MAX : shift_q;
   assign cyc_eff_s     = (cyc_q > CYC_MAX) ? DW'(MAX_CYC_DELAY - 1) : cyc_q[DW-1:0];
   assign cal_len_eff_s = (cal_len_q == 8'd0) ? 8'd1 : cal_len_q;
   assign rise_s        = del_trig & ~trig_q;

   // register map write decode
   always_ff @(posedge clk) begin
      if (rst) begin
         gpio_q      <= 25'd0;
         wclk_prev_q <= 1'b0;
         mode_q      <= 2'd0;
         shift_q     <= 8'd0;
         cyc_q       <= 8'd0;
         cal_len_q   <= 8'd0;
         static_q    <= {W{1'b0}};
      end else begin
         gpio_q      <= gpio_in[24:0];
         wclk_prev_q <= gpio_q[24];
         if (wr_fire_s) begin
            case (wr_off_s)
               16'd0:   mode_q    <= wr_data_s[1:0];
               16'd1:   shift_q   <= wr_data_s;
               16'd2:   cyc_q     <= wr_data_s;
               16'd3:   cal_len_q <= wr_data_s;
               default: begin
                  for (int i = 0; i < NB; i++) begin
                     if (wr_off_s == 16'(16 + i)) begin
                        static_q[i*8 +: 8] <= wr_data_s;
                     end
                  end
               end
            endcase
         end
      end
   end

   // ramp word for the current cycle count
   always_comb begin
      ramp_word_s = {W{1'b0}};
      ramp_base_s = ramp_c_q * SAMPLE_W'(NUM_SAMPLES);
      for (int k = 0; k < NUM_SAMPLES; k++) begin
         ramp_word_s[k*SAMPLE_W +: SAMPLE_W] = ramp_base_s + SAMPLE_W'(k);
      end
   end

   // stage-1 next state: calibration counter, ramp counter and source mux
   always_comb begin
      // Counter counts down while the static word is emitted; a trigger is
      // only accepted when idle, and any other mode clears it.
      if (mode_q != 2'd2) begin
         cal_cnt_d = 8'd0;
      end else if (cal_cnt_q != 8'd0) begin
         cal_cnt_d = cal_cnt_q - 8'd1;
      end else if (rise_s) begin
         cal_cnt_d = cal_len_eff_s;
      end else begin
         cal_cnt_d = 8'd0;
      end

      // Ramp restarts at c = 0 whenever mode 3 is written.
      if (wr_fire_s && (wr_off_s == 16'd0) && (wr_data_s[1:0] == 2'd3)) begin
         ramp_c_d = {SAMPLE_W{1'b0}};
      end else if (mode_q == 2'd3) begin
         ramp_c_d = ramp_c_q + SAMPLE_W'(1);
      end else begin
         ramp_c_d = ramp_c_q;
      end

      case (mode_q)
         2'd0: begin
            s1_data_d  = fsm_in_valid ? fsm_val_in : {W{1'b0}};
            s1_valid_d = fsm_in_valid;
         end
         2'd1: begin
            s1_data_d  = static_q;
            s1_valid_d = 1'b1;
         end
         2'd2: begin
            s1_data_d  = (cal_cnt_q != 8'd0) ? static_q : {W{1'b0}};
            s1_valid_d = 1'b1;
         end
         2'd3: begin
            s1_data_d  = ramp_word_s;
            s1_valid_d = 1'b1;
         end
         default: begin
            s1_data_d  = {W{1'b0}};
            s1_valid_d = 1'b0;
         end
      endcase
   end

   // stage-1 registers
   always_ff @(posedge clk) begin
      if (rst) begin
         trig_q     <= 1'b0;
         cal_cnt_q  <= 8'd0;
         cal_busy_q <= 1'b0;
         ramp_c_q   <= {SAMPLE_W{1'b0}};
         s1_data_q  <= {W{1'b0}};
         s1_valid_q <= 1'b0;
      end else begin
         trig_q     <= del_trig;
         cal_cnt_q  <= cal_cnt_d;
         cal_busy_q <= (cal_cnt_d != 8'd0);
         ramp_c_q   <= ramp_c_d;
         s1_data_q  <= s1_data_d;
         s1_valid_q <= s1_valid_d;
      end
   end

   // Reading wr_ptr - d before this edge's write yields d cycles of extra
   // delay; d = 0 bypasses the buffer.
   assign rd_idx_s = wr_ptr_q - cyc_eff_s;

   // stage 2: circular delay line
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MAX_CYC_DELAY; i++) begin
            dl_mem_q[i] <= {W{1'b0}};
         end
         dl_vld_q        <= {MAX_CYC_DELAY{1'b0}};
         wr_ptr_q        <= {DW{1'b0}};
         s2_data_q       <= {W{1'b0}};
         s2_valid_q      <= 1'b0;
         s2_prev_q       <= {W{1'b0}};
         s2_prev_valid_q <= 1'b0;
      end else begin
         dl_mem_q[wr_ptr_q] <= s1_data_q;
         dl_vld_q[wr_ptr_q] <= s1_valid_q;
         wr_ptr_q           <= wr_ptr_q + DW'(1);
         if (cyc_eff_s == {DW{1'b0}}) begin
            s2_data_q  <= s1_data_q;
            s2_valid_q <= s1_valid_q;
         end else begin
            s2_data_q  <= dl_mem_q[rd_idx_s];
            s2_valid_q <= dl_vld_q[rd_idx_s];
         end
         s2_prev_q       <= s2_data_q;
         s2_prev_valid_q <= s2_valid_q;
      end
   end

   // Output sample k is concatenated sample N+k-shift: a right shift of the
   // {cur, prev} pair by (N - shift) samples.
   assign cat_s   = {s2_data_q, s2_prev_q};
   assign shamt_s = 16'(W) - (16'(shift_eff_s) * 16'(SAMPLE_W));

   // stage 3: sample shifter and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q       <= {W{1'b0}};
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= W'(cat_s >> shamt_s);
         out_valid_q <= s2_valid_q | ((shift_eff_s != 8'd0) & s2_prev_valid_q);
      end
   end

   assign dac_out       = out_q;
   assign dac_out_valid = out_valid_q;
   assign cal_busy      = cal_busy_q;

endmodule

// File: tb/tb_dac_stream_driver.sv
module tb_dac_stream_driver;

   localparam int SW = 16;
   localparam int N  = 16;
   localparam int W  = SW * N;
   localparam int NB = W / 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   gpio_in;
   logic [W-1:0]  fsm_val_in;
   logic          fsm_in_valid;
   logic          del_trig;
   logic [W-1:0]  dac_out;
   logic          dac_out_valid;
   logic          cal_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dac_stream_driver #(
      .SAMPLE_W(SW), .NUM_SAMPLES(N), .MAX_CYC_DELAY(16), .BASE_ADDR(0)
   ) dut (
      .clk(clk), .rst(rst), .gpio_in(gpio_in),
      .fsm_val_in(fsm_val_in), .fsm_in_valid(fsm_in_valid),
      .del_trig(del_trig), .dac_out(dac_out),
      .dac_out_valid(dac_out_valid), .cal_busy(cal_busy)
   );

   typedef struct {
      logic [7:0] cyc;
      logic [7:0] shift;
      int         lat;
      int         eff_shift;
   } vec_t;

   vec_t vt [6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_w(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic chk_i(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      gpio_in = {7'd0, 1'b1, d, a};
      tick();
      gpio_in = {7'd0, 1'b0, d, a};
      tick();
   endtask

   // Edges from the first capture edge until dac_out_valid is seen (-1 if never).
   task automatic measure(input int budget, output int lat);
      lat = 0;
      do begin
         tick();
         fsm_in_valid = 1'b0;
         lat++;
      end while (!dac_out_valid && lat < budget);
      if (!dac_out_valid) lat = -1;
   endtask

   function automatic logic [W-1:0] seq_word(input int first);
      logic [W-1:0] w;
      for (int k = 0; k < N; k++) w[k*SW +: SW] = 16'(first + k);
      return w;
   endfunction

   // Expected output for a shift of s samples given current and previous words.
   function automatic logic [W-1:0] shifted(input logic [W-1:0] cur, input logic [W-1:0] prev, input int s);
      logic [W-1:0] w;
      for (int k = 0; k < N; k++) begin
         if (k >= s) w[k*SW +: SW] = cur[(k-s)*SW +: SW];
         else        w[k*SW +: SW] = prev[(N+k-s)*SW +: SW];
      end
      return w;
   endfunction

   // Trigger a calibration pulse and observe 12 cycles.
   task automatic cal_run(input bit retrig, output int busy_n, output int stat_n,
                          output int bad_n, output int first_i);
      logic [W-1:0] stat_w;
      stat_w  = {16{16'h7FFF}};
      busy_n  = 0;
      stat_n  = 0;
      bad_n   = 0;
      first_i = -1;
      del_trig = 1'b1;
      tick();
      for (int i = 0; i < 12; i++) begin
         if (retrig && i == 0) del_trig = 1'b0;
         if (retrig && i == 1) del_trig = 1'b1;
         busy_n += int'(cal_busy);
         if (dac_out === stat_w) begin
            stat_n++;
            if (first_i < 0) first_i = i;
         end else if (dac_out !== {W{1'b0}} || dac_out_valid !== 1'b1) begin
            bad_n++;
         end
         tick();
      end
      del_trig = 1'b0;
      tick();
   endtask

   initial begin
      int lat, busy_n, stat_n, bad_n, first_i;
      logic [W-1:0] stat_w;
      stat_w = {16{16'h7FFF}};

      vt[0] = '{8'd0,  8'd0,  3,  0};
      vt[1] = '{8'd5,  8'd0,  8,  0};
      vt[2] = '{8'd40, 8'd0,  18, 0};
      vt[3] = '{8'd15, 8'd0,  18, 0};
      vt[4] = '{8'd1,  8'd3,  4,  3};
      vt[5] = '{8'd0,  8'd20, 3,  15};

      rst = 1'b1; gpio_in = 32'd0; fsm_val_in = {W{1'b0}};
      fsm_in_valid = 1'b0; del_trig = 1'b0;
      repeat (3) tick();
      chk_w("rst_out", dac_out, {W{1'b0}});
      chk_i("rst_valid", int'(dac_out_valid), 0);
      chk_i("rst_busy", int'(cal_busy), 0);
      rst = 1'b0;
      tick();

      // single-word stream through varied delay/shift settings
      for (int v = 0; v < 6; v++) begin
         wr(16'd2, vt[v].cyc);
         wr(16'd1, vt[v].shift);
         repeat (20) tick();
         fsm_val_in = seq_word(1);
         fsm_in_valid = 1'b1;
         measure(40, lat);
         chk_i("tbl_lat", lat, vt[v].lat);
         chk_w("tbl_word0", dac_out, shifted(seq_word(1), {W{1'b0}}, vt[v].eff_shift));
         tick();
         chk_w("tbl_word1", dac_out, shifted({W{1'b0}}, seq_word(1), vt[v].eff_shift));
         chk_i("tbl_valid1", int'(dac_out_valid), int'(vt[v].eff_shift != 0));
      end

      // back-to-back words A, B with shift 3
      wr(16'd2, 8'd0);
      wr(16'd1, 8'd3);
      repeat (20) tick();
      fsm_val_in = seq_word(1);  fsm_in_valid = 1'b1; tick();
      fsm_val_in = seq_word(17); tick();
      fsm_in_valid = 1'b0;
      tick();
      chk_w("ab_w0", dac_out, shifted(seq_word(1), {W{1'b0}}, 3));
      tick();
      chk_w("ab_w1", dac_out, seq_word(14));
      chk_i("ab_v1", int'(dac_out_valid), 1);
      tick();
      chk_w("ab_w2", dac_out, shifted({W{1'b0}}, seq_word(17), 3));
      wr(16'd1, 8'd0);

      // calibration pulse
      for (int i = 0; i < NB; i++) wr(16'(16 + i), (i % 2 == 1) ? 8'h7F : 8'hFF);
      wr(16'd3, 8'd3);
      wr(16'd0, 8'd2);
      repeat (10) tick();
      chk_w("cal_idle_out", dac_out, {W{1'b0}});
      chk_i("cal_idle_valid", int'(dac_out_valid), 1);
      cal_run(1'b1, busy_n, stat_n, bad_n, first_i);
      chk_i("cal_busy_cycles", busy_n, 3);
      chk_i("cal_static_words", stat_n, 3);
      chk_i("cal_first_word", first_i, 3);
      chk_i("cal_bad_words", bad_n, 0);
      wr(16'd3, 8'd0);
      cal_run(1'b0, busy_n, stat_n, bad_n, first_i);
      chk_i("cal0_busy_cycles", busy_n, 1);
      chk_i("cal0_static_words", stat_n, 1);

      // static mode latency including clamped delay
      for (int v = 0; v < 2; v++) begin
         wr(16'd0, 8'd0);
         wr(16'd2, (v == 0) ? 8'd5 : 8'd40);
         repeat (20) tick();
         wr(16'd0, 8'd1);
         measure(40, lat);
         chk_i("static_lat", lat, (v == 0) ? 8 : 18);
         chk_w("static_word", dac_out, stat_w);
      end

      // ramp pattern
      wr(16'd2, 8'd0);
      wr(16'd0, 8'd3);
      repeat (3) tick();
      chk_w("ramp_c0", dac_out, seq_word(0));
      chk_i("ramp_v0", int'(dac_out_valid), 1);
      tick();
      chk_w("ramp_c1", dac_out, seq_word(16));
      repeat (4095) tick();
      chk_w("ramp_wrap", dac_out, seq_word(0));

      // reset mid calibration pulse
      wr(16'd3, 8'd200);
      wr(16'd0, 8'd2);
      tick();
      del_trig = 1'b1;
      repeat (5) tick();
      chk_i("pulse_busy", int'(cal_busy), 1);
      rst = 1'b1; tick();
      chk_w("rstp_out", dac_out, {W{1'b0}});
      chk_i("rstp_valid", int'(dac_out_valid), 0);
      chk_i("rstp_busy", int'(cal_busy), 0);
      rst = 1'b0;
      repeat (3) tick();
      chk_i("rstp_busy_after", int'(cal_busy), 0);
      del_trig = 1'b0;

      // reset mid stream; defaults give mode 0, no delay
      fsm_val_in = seq_word(100); fsm_in_valid = 1'b1;
      repeat (5) tick();
      chk_w("strm_out", dac_out, seq_word(100));
      rst = 1'b1; tick();
      chk_w("rsts_out", dac_out, {W{1'b0}});
      chk_i("rsts_valid", int'(dac_out_valid), 0);
      rst = 1'b0;
      measure(10, lat);
      chk_i("rsts_lat", lat, 3);
      chk_w("rsts_word", dac_out, seq_word(100));
      wr(16'd0, 8'd1);
      repeat (8) tick();
      chk_w("rsts_static", dac_out, {W{1'b0}});
      chk_i("rsts_static_v", int'(dac_out_valid), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
